// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M encodings and FSM state type for the EX mul/div unit
package muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX to mul/div unit handshake and result bundle
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit in the EX stage
import muldiv_pkg::*;

module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  state_t            state_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              a_neg, b_neg, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step_d;
  logic [XLEN-1:0]   mul_hi, mul_lo, quo_fix, rem_fix, fix_res;

  always_comb begin
    a_neg = bus.op_a[XLEN-1] && (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU ||
                                 bus.funct3 == F3_DIV  || bus.funct3 == F3_REM);
    b_neg = bus.op_b[XLEN-1] && (bus.funct3 == F3_MULH || bus.funct3 == F3_DIV ||
                                 bus.funct3 == F3_REM);
    a_mag = a_neg ? -bus.op_a : bus.op_a;
    b_mag = b_neg ? -bus.op_b : bus.op_b;
    // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
    neg_d = (bus.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

    special     = 1'b0;
    special_res = '0;
    if (bus.funct3[2]) begin
      if (bus.op_b == '0) begin
        special     = 1'b1;
        special_res = bus.funct3[1] ? bus.op_a : '1;
      end else if (!bus.funct3[0] && bus.op_b == '1 &&
                   bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) begin
        special     = 1'b1;
        special_res = bus.funct3[1] ? '0 : bus.op_a;
      end
    end
  end

  // Shared iteration: prod_q holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){prod_q[0]}});
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (f3_q[2]) begin
      step_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
    end else begin
      step_d = {mul_sum, prod_q[XLEN-1:1]};
    end
  end

  always_comb begin
    {mul_hi, mul_lo} = neg_q ? -prod_q : prod_q;
    quo_fix = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       fix_res = mul_lo;
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = mul_hi;
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          f3_q  <= bus.funct3;
          rd_q  <= bus.rd_in;
          neg_q <= neg_d;
          if (special) begin
            result_q <= special_res;
            rd_out_q <= bus.rd_in;
            state_q  <= DONE;
          end else begin
            opnd_q  <= bus.funct3[2] ? b_mag : a_mag;
            prod_q  <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
            cnt_q   <= CW'(XLEN - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          prod_q <= step_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          rd_out_q <= rd_q;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall  = (state_q == IDLE && bus.start && !bus.flush) ||
                      state_q == CALC || state_q == FIX;
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();
  ex_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat = -1;
    int stall_low = 0;
    logic [31:0] res = '0;
    logic [4:0]  rdo = '0;
    logic        st_done = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    #1;
    check({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = c; res = bus.result; rdo = bus.rd_out; st_done = bus.stall;
        break;
      end
      if (!bus.stall) stall_low++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, res, exp_res);
    check({tag, "_rd_out"}, 32'(rdo), 32'(rd));
    check({tag, "_stall_busy"}, 32'(stall_low), 32'd0);
    check({tag, "_stall_done"}, 32'(st_done), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n_done;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    bus.start = 0; bus.funct3 = 0; bus.op_a = 0; bus.op_b = 0; bus.rd_in = 0; bus.flush = 0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 34);
    run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 34);
    run_op("mulhsu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 34);
    run_op("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34);
    run_op("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34);
    run_op("divu_zero", 3'd5, 32'h1234, 32'd0, 5'd9, 32'hFFFFFFFF, 1);
    run_op("remu_zero", 3'd7, 32'h1234, 32'd0, 5'd10, 32'h1234, 1);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, 1);

    // Flush mid-divide, then a fresh multiply two cycles later.
    n_done = 0;
    @(negedge clk);
    bus.start = 1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 0;
      if (bus.done) n_done++;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) n_done++;
    check("flush_stall", 32'(bus.stall), 32'd0);
    check("flush_no_done", 32'(n_done), 32'd0);
    run_op("post_flush_mul", 3'd0, 32'd3, 32'd5, 5'd14, 32'd15, 34);

    // Flush wins over start in IDLE.
    n_done = 0;
    @(negedge clk);
    bus.start = 1; bus.flush = 1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    #1;
    check("flush_beats_start_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 0; bus.flush = 0;
    check("flush_beats_start_idle", 32'(bus.stall), 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("flush_beats_start_done", 32'(n_done), 32'd0);

    // start held through DONE yields one pulse.
    n_done = 0;
    @(negedge clk);
    bus.start = 1; bus.funct3 = 3'd3; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.rd_in = 5'd15;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        check("hold_stall_done", 32'(bus.stall), 32'd0);
        check("hold_lat", 32'(c), 32'd34);
        bus.start = 0;
      end
    end
    check("hold_one_done", 32'(n_done), 32'd1);

    // Reset during a divide clears outputs and suppresses done.
    n_done = 0;
    @(negedge clk);
    bus.start = 1; bus.funct3 = 3'd4; bus.op_a = 32'd77; bus.op_b = 32'd5; bus.rd_in = 5'd16;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_rd_out", 32'(bus.rd_out), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 15) == 0) b = $urandom_range(0, 9);
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, 5'($urandom), ref_model(f3, a, b),
             ref_latency(f3, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes operands, funct3 and rd of an M-extension R-type instruction held in ID/EX.
- Computes the result over multiple cycles while asserting stall, which freezes PC, IF/ID and ID/EX (write=0).
- Presents the result for one cycle so the EX-stage result mux forwards it into EX/MEM.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  ID/EX holds a valid M-extension op (opcode 0110011, funct7 0000001)
funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value after forwarding
op_b  in  XLEN  rs2 value after forwarding
rd_in  in  5  destination register of the op
flush  in  1  kill the in-flight op (branch taken / exception)
stall  out  1  freeze upstream pipeline registers
done  out  1  result valid, one-cycle pulse
result  out  XLEN  RV32M result
rd_out  out  5  destination register of the completed op

Behaviour:
- Reset: state=IDLE; done=0, result=0, rd_out=0, stall=0; counter, accumulators and latched funct3/signs cleared. Reset mid-operation aborts with no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, normal case:
  - latch funct3, rd_in and operand signs;
  - load |op_a| and |op_b| (signed ops only);
  - counter=XLEN-1; go to CALC.
- IDLE, start=1, special case: go straight to DONE with the precomputed result.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract; quotient and remainder registers.
  - Counter decrements; at counter=0, go to FIX.
- FIX (one cycle):
  - Apply sign correction:
    - MULH/DIV/REM: negate by the XOR of operand signs, or by the dividend sign for REM.
    - MULHSU: only op_a is signed.
  - Select the low half (MUL) or high half (MULH*) of the product.
  - Register result; go to DONE.
- DONE: done=1, result and rd_out valid for exactly this cycle; always go to IDLE next.
- stall is combinational: 1 when (state==IDLE and start and not flush) or state is CALC or FIX; 0 in DONE. ID/EX therefore advances on the DONE edge.
- start is ignored in every state except IDLE. The op still visible in ID/EX during DONE is not restarted.
- Latency: start high in cycle 0 → done high in cycle XLEN+2 (34). Special cases → done in cycle 1.
- flush, any state: next state IDLE, done=0, stall=0 from the following cycle. Flush beats start in IDLE.
- result and rd_out hold their last value outside DONE; consumers qualify with done.
- Width rules:
  - Product register is 2*XLEN.
  - Divider partial remainder is XLEN+1 bits for the subtract.
  - Negation is two's complement modulo 2^XLEN (2^2XLEN for the product).

Decomposition:
- Shared package muldiv_pkg holds:
  - MULDIV_FUNCT7 = 7'b0000001 and OPCODE_OP = 7'b0110011;
  - funct3 encodings F3_MUL..F3_REMU;
  - the state enum (IDLE, CALC, FIX, DONE).
- No sub-module: multiply and divide share the counter, shift registers and FSM in one module.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) → done at cycle 34, result=0xFFFFFFEB; stall high cycles 0-33, low at 34.
- MULH 0x80000000 × 0x80000000 → result=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3). REM same operands → 0xFFFFFFFF (-1). DIVU 100/7 → 14; REMU → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF with done at cycle 1; REMU → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1; REM → 0.
- DIV in progress, flush=1 at cycle 10 → no done pulse, stall=0 at cycle 11. New MUL 3×5 started at cycle 12 → result 15 at cycle 46, rd_out matches its rd_in.
- Back-to-back: start held high through DONE (same op) → exactly one done pulse. Reset asserted at cycle 5 of a DIV → all outputs 0 next cycle, no done.
